cajero_controlador: RTL and testbench

- FSM controller for an automated teller machine.
- Receives a card-present flag, a 4-digit PIN entered digit by digit, a transaction type and an amount.
- Validates the PIN against the card's stored PIN and keeps a running account balance.
- Drives single-cycle result flags to the ATM front-end: dispense, balance updated, wrong PIN, warning, insufficient funds, and a sticky block flag.

---
 rtl/cajero_pkg.sv | 15 +
 rtl/cajero_controlador.sv | 155 +++++++++++++++
 tb/tb_cajero_controlador.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cajero_pkg.sv
// Shared types and constants for the ATM controller.
package cajero_pkg;

  typedef enum logic [1:0] {
    ESPERANDO_TARJETA = 2'd0,
    INGRESANDO_PIN    = 2'd1,
    ESPERANDO_MONTO   = 2'd2,
    BLOQUEO           = 2'd3
  } estado_t;

  localparam int   MAX_INTENTOS  = 3;
  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_controlador.sv
// ATM controller: PIN entry with three-strike lockout, deposits and withdrawals
// against a persistent balance, registered single-cycle result flags.
module cajero_controlador
  import cajero_pkg::*;
#(
  parameter int                   BALANCE_W       = 64,
  parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = 64'd1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TIPO_TRANS,
  input  logic        DIGITO_STB,
  input  logic        MONTO_STB,
  input  logic [3:0]  DIGITO,
  input  logic [15:0] PIN,
  input  logic [31:0] MONTO,
  output logic        BALANCE_ACTUALIZADO,
  output logic        ENTREGAR_DINERO,
  output logic        PIN_INCORRECTO,
  output logic        ADVERTENCIA,
  output logic        BLOQUEO_CTRL,
  output logic        FONDOS_INSUFICIENTES
);

  estado_t              r_estado, w_estado_sig;
  logic [11:0]          r_pin_reg, w_pin_sig;
  logic [1:0]           r_cuenta, w_cuenta_sig;
  logic [1:0]           r_intentos, w_intentos_sig;
  logic [BALANCE_W-1:0] r_balance, w_balance_sig;
  logic [BALANCE_W-1:0] w_monto_ext;
  logic                 w_pin_ok;
  logic                 w_act, w_ent, w_inc, w_adv, w_fon;
  logic                 r_act, r_ent, r_inc, r_adv, r_fon, r_blq;

  assign w_monto_ext = {{(BALANCE_W-32){1'b0}}, MONTO};
  assign w_pin_ok    = ({r_pin_reg, DIGITO} == PIN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_estado   <= ESPERANDO_TARJETA;
      r_pin_reg  <= 12'h000;
      r_cuenta   <= 2'd0;
      r_intentos <= 2'd0;
      r_balance  <= BALANCE_INICIAL;
      r_act      <= 1'b0;
      r_ent      <= 1'b0;
      r_inc      <= 1'b0;
      r_adv      <= 1'b0;
      r_fon      <= 1'b0;
      r_blq      <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_pin_reg  <= w_pin_sig;
      r_cuenta   <= w_cuenta_sig;
      r_intentos <= w_intentos_sig;
      r_balance  <= w_balance_sig;
      r_act      <= w_act;
      r_ent      <= w_ent;
      r_inc      <= w_inc;
      r_adv      <= w_adv;
      r_fon      <= w_fon;
      r_blq      <= (w_estado_sig == BLOQUEO);
    end
  end

  always_comb begin
    w_estado_sig   = r_estado;
    w_pin_sig      = r_pin_reg;
    w_cuenta_sig   = r_cuenta;
    w_intentos_sig = r_intentos;
    w_balance_sig  = r_balance;
    w_act          = 1'b0;
    w_ent          = 1'b0;
    w_inc          = 1'b0;
    w_adv          = 1'b0;
    w_fon          = 1'b0;
    case (r_estado)
      ESPERANDO_TARJETA: begin
        w_cuenta_sig   = 2'd0;
        w_intentos_sig = 2'd0;
        w_pin_sig      = 12'h000;
        if (TARJETA_RECIBIDA) begin
          w_estado_sig = INGRESANDO_PIN;
        end else begin
          w_estado_sig = ESPERANDO_TARJETA;
        end
      end
      INGRESANDO_PIN: begin
        // Card removal wins over a digit arriving in the same cycle.
        if (!TARJETA_RECIBIDA) begin
          w_estado_sig   = ESPERANDO_TARJETA;
          w_cuenta_sig   = 2'd0;
          w_intentos_sig = 2'd0;
        end else if (DIGITO_STB) begin
          w_pin_sig = {r_pin_reg[7:0], DIGITO};
          if (r_cuenta == 2'd3) begin
            w_cuenta_sig = 2'd0;
            if (w_pin_ok) begin
              w_estado_sig   = ESPERANDO_MONTO;
              w_intentos_sig = 2'd0;
            end else if (r_intentos == 2'(MAX_INTENTOS - 1)) begin
              w_estado_sig = BLOQUEO;
              w_inc        = 1'b1;
            end else begin
              w_intentos_sig = r_intentos + 2'd1;
              w_inc          = 1'b1;
              w_adv          = (r_intentos == 2'd1);
            end
          end else begin
            w_cuenta_sig = r_cuenta + 2'd1;
          end
        end else begin
          w_estado_sig = INGRESANDO_PIN;
        end
      end
      ESPERANDO_MONTO: begin
        if (!TARJETA_RECIBIDA) begin
          w_estado_sig   = ESPERANDO_TARJETA;
          w_intentos_sig = 2'd0;
        end else if (MONTO_STB) begin
          w_estado_sig = ESPERANDO_TARJETA;
          case (TIPO_TRANS)
            TIPO_DEPOSITO: begin
              w_balance_sig = r_balance + w_monto_ext;
              w_act         = 1'b1;
            end
            TIPO_RETIRO: begin
              if (w_monto_ext <= r_balance) begin
                w_balance_sig = r_balance - w_monto_ext;
                w_act         = 1'b1;
                w_ent         = 1'b1;
              end else begin
                w_fon = 1'b1;
              end
            end
            default: w_estado_sig = ESPERANDO_TARJETA;
          endcase
        end else begin
          w_estado_sig = ESPERANDO_MONTO;
        end
      end
      BLOQUEO: w_estado_sig = BLOQUEO;
      default: w_estado_sig = ESPERANDO_TARJETA;
    endcase
  end

  assign BALANCE_ACTUALIZADO  = r_act;
  assign ENTREGAR_DINERO      = r_ent;
  assign PIN_INCORRECTO       = r_inc;
  assign ADVERTENCIA          = r_adv;
  assign BLOQUEO_CTRL         = r_blq;
  assign FONDOS_INSUFICIENTES = r_fon;

endmodule

// File: tb/tb_cajero_controlador.sv
// Scoreboard bench for cajero_controlador: each driven cycle queues the
// expected flags (and optionally balance); a monitor pops and compares.
module tb_cajero_controlador;

  localparam logic [5:0] F_ACT = 6'b000001;
  localparam logic [5:0] F_ENT = 6'b000010;
  localparam logic [5:0] F_INC = 6'b000100;
  localparam logic [5:0] F_ADV = 6'b001000;
  localparam logic [5:0] F_FON = 6'b010000;
  localparam logic [5:0] F_BLQ = 6'b100000;
  localparam logic [5:0] F_NIN = 6'b000000;

  typedef struct {
    logic [5:0]  flags;
    logic [63:0] bal;
    bit          chk_bal;
    int          paso_id;
  } esperado_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        TARJETA_RECIBIDA = 1'b0;
  logic        TIPO_TRANS = 1'b0;
  logic        DIGITO_STB = 1'b0;
  logic        MONTO_STB = 1'b0;
  logic [3:0]  DIGITO = 4'h0;
  logic [15:0] PIN = 16'h1234;
  logic [31:0] MONTO = 32'd0;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO;
  logic        ADVERTENCIA, BLOQUEO_CTRL, FONDOS_INSUFICIENTES;

  esperado_t   cola[$];
  int          n_aserciones = 0;
  int          n_fallos = 0;
  int          n_paso = 0;
  logic [63:0] exp_bal = 64'd1000;

  cajero_controlador dut (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
    .TIPO_TRANS(TIPO_TRANS), .DIGITO_STB(DIGITO_STB), .MONTO_STB(MONTO_STB),
    .DIGITO(DIGITO), .PIN(PIN), .MONTO(MONTO),
    .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
    .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA),
    .BLOQUEO_CTRL(BLOQUEO_CTRL), .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES)
  );

  always #5 CLK = ~CLK;

  task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_aserciones++;
    if (obs !== exp) begin
      n_fallos++;
      $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, exp);
    end
  endtask

  // Outputs settle one cycle after the sampling edge; check 1 time unit later.
  always @(posedge CLK) begin
    #1;
    if (cola.size() > 0) begin
      esperado_t e;
      e = cola.pop_front();
      comprobar($sformatf("flags paso %0d", e.paso_id),
                {58'd0, FONDOS_INSUFICIENTES, BLOQUEO_CTRL, ADVERTENCIA,
                 PIN_INCORRECTO, ENTREGAR_DINERO, BALANCE_ACTUALIZADO},
                {58'd0, e.flags[4], e.flags[5], e.flags[3], e.flags[2], e.flags[1], e.flags[0]});
      if (e.chk_bal) begin
        comprobar($sformatf("balance paso %0d", e.paso_id), dut.r_balance, e.bal);
      end
    end
  end

  task automatic paso(input logic rst, input logic tar, input logic dstb, input logic [3:0] dig,
                      input logic mstb, input logic tipo, input logic [31:0] monto,
                      input logic [5:0] flags, input bit chk_bal);
    esperado_t e;
    @(negedge CLK);
    RESET = rst; TARJETA_RECIBIDA = tar; DIGITO_STB = dstb; DIGITO = dig;
    MONTO_STB = mstb; TIPO_TRANS = tipo; MONTO = monto;
    n_paso++;
    e.flags = flags; e.bal = exp_bal; e.chk_bal = chk_bal; e.paso_id = n_paso;
    cola.push_back(e);
    @(posedge CLK);
  endtask

  task automatic reiniciar(input int ciclos);
    exp_bal = 64'd1000;
    for (int i = 0; i < ciclos; i++) paso(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 32'd5, F_NIN, 1'b1);
  endtask

  task automatic insertar();
    paso(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'd0, F_NIN, 1'b0);
  endtask

  task automatic retirar_tarjeta(input logic [5:0] flags);
    paso(1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 32'd0, flags, 1'b0);
  endtask

  task automatic digitos(input logic [15:0] p, input int n, input logic [5:0] ultima);
    for (int i = 0; i < n; i++)
      paso(1'b0, 1'b1, 1'b1, p[15-4*i -: 4], 1'b0, 1'b0, 32'd0,
           (i == 3) ? ultima : F_NIN, 1'b0);
  endtask

  task automatic transaccion(input logic tipo, input logic [31:0] monto, input logic [5:0] flags);
    paso(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, tipo, monto, flags, 1'b1);
  endtask

  initial begin
    reiniciar(2);
    // Deposit 500
    insertar(); digitos(16'h1234, 4, F_NIN);
    exp_bal = 64'd1500; transaccion(1'b0, 32'd500, F_ACT);
    // Withdraw 300, then an oversized withdrawal
    insertar(); digitos(16'h1234, 4, F_NIN);
    exp_bal = 64'd1200; transaccion(1'b1, 32'd300, F_ACT | F_ENT);
    insertar(); digitos(16'h1234, 4, F_NIN);
    transaccion(1'b1, 32'd2000, F_FON);
    // Two wrong PINs, then correct; stray strobes in wrong states ignored
    insertar();
    paso(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'd1, F_NIN, 1'b1);
    digitos(16'h1235, 4, F_INC);
    digitos(16'h1235, 4, F_INC | F_ADV);
    digitos(16'h1234, 4, F_NIN);
    paso(1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 32'd0, F_NIN, 1'b1);
    exp_bal = 64'd1000; transaccion(1'b1, 32'd200, F_ACT | F_ENT);
    insertar(); digitos(16'h1234, 4, F_NIN);
    exp_bal = 64'd1007; transaccion(1'b0, 32'd7, F_ACT);
    // Lockout after three wrong PINs, then sticky through any activity
    insertar();
    digitos(16'h0000, 4, F_INC);
    digitos(16'hABCD, 4, F_INC | F_ADV);
    digitos(16'h4321, 4, F_INC | F_BLQ);
    retirar_tarjeta(F_BLQ);
    insertar_blq: begin
      paso(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'd0, F_BLQ, 1'b0);
      for (int i = 0; i < 4; i++)
        paso(1'b0, 1'b1, 1'b1, 4'(i + 1), 1'b1, 1'b0, 32'd50, F_BLQ, 1'b1);
      paso(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'd1, F_BLQ, 1'b1);
    end
    reiniciar(1);
    // Removal clears partial PIN and attempts
    insertar();
    digitos(16'h1235, 4, F_INC);
    digitos(16'h1234, 2, F_NIN);
    retirar_tarjeta(F_NIN);
    insertar();
    digitos(16'h1235, 4, F_INC);
    digitos(16'h1235, 4, F_INC | F_ADV);
    digitos(16'h1234, 4, F_NIN);
    exp_bal = 64'd0; transaccion(1'b1, 32'd1000, F_ACT | F_ENT);
    // Reset in the middle of PIN entry
    insertar(); digitos(16'h1234, 2, F_NIN);
    reiniciar(1);
    insertar(); digitos(16'h1234, 4, F_NIN);
    transaccion(1'b1, 32'd1001, F_FON);
    repeat (3) @(posedge CLK);
    comprobar("cola vacia", 64'(cola.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_aserciones, n_fallos);
    $finish;
  end

endmodule
